// File: rtl/tri_state_bus_arb.sv
// tri_state_bus_arb
//
// Registered, multi-channel tri-state bus driver with a round-robin arbiter.
// Each of NUM_CH channels owns a WIDTH-bit register. One channel at a time is
// granted the shared tri-state bus. Between two owners there is always exactly
// one high-Z turnaround cycle, so no two drivers can ever overlap on the bus.
//
// Optional feature macro: TRI_BUS_TIMEOUT_EN
//   defined   - a hold counter limits each grant to MAX_HOLD DRIVE cycles
//   undefined - no counter; an owner keeps the bus while it requests
//
// Parameters:
//   WIDTH    - bits per channel register and bus width (>=1)
//   NUM_CH   - number of channels (2..16)
//   MAX_HOLD - DRIVE-cycle limit per grant (only with TRI_BUS_TIMEOUT_EN)
//
// Ports:
//   clk      - system clock, all state changes on posedge
//   rst      - synchronous active-high reset
//   ld       - per-channel load strobe, ld[i] captures d slice i
//   d        - load data, channel i at bits [i*WIDTH +: WIDTH]
//   req      - per-channel level-sensitive bus request
//   gnt      - registered one-hot grant, all-zero when the bus has no owner
//   bus      - owner's register while bus_vld=1, otherwise all 'z
//   bus_vld  - high exactly when bus is actively driven
//   q        - readback of all channel registers

module tri_state_bus_arb #(
   parameter int WIDTH    = 8,
   parameter int NUM_CH   = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       ld,
   input  logic [NUM_CH*WIDTH-1:0] d,
   input  logic [NUM_CH-1:0]       req,
   output logic [NUM_CH-1:0]       gnt,
   output tri   [WIDTH-1:0]        bus,
   output logic                    bus_vld,
   output logic [NUM_CH*WIDTH-1:0] q
);

   localparam int PW = $clog2(NUM_CH);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      TURN
   } state_t;

   state_t                       state_q, state_d;
   logic [NUM_CH-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [NUM_CH-1:0]            gnt_q, gnt_d;
   logic [PW-1:0]                owner_q, owner_d;
   logic [PW-1:0]                ptr_q, ptr_d;

   logic                         any_req;
   logic [PW-1:0]                win;
   logic [PW-1:0]                cand;
   logic [PW-1:0]                ptr_nxt;
   logic                         timeout_hit;

   // Channel registers load independently of arbitration.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ld[i]) begin
            regs_d[i] = d[i*WIDTH +: WIDTH];
         end
      end
   end

   // Round-robin search: start at ptr, wrap upward, first set request wins.
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      cand    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = PW'((int'(ptr_q) + k) % NUM_CH);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            win     = cand;
         end
      end
      ptr_nxt = (win == PW'(NUM_CH - 1)) ? '0 : win + 1'b1;
   end

`ifdef TRI_BUS_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);

   logic [HW-1:0] hold_q, hold_d;

   // Counts completed DRIVE cycles of the current grant; zero on DRIVE entry.
   always_comb begin
      hold_d = '0;
      if (state_q == DRIVE) begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign timeout_hit = (state_q == DRIVE) && (hold_q == HW'(MAX_HOLD - 1));
`else
   // No hold limit in this build; MAX_HOLD is non-negative so this is constant 0.
   assign timeout_hit = (MAX_HOLD < 0);
`endif

   // Next-state, grant and pointer logic. Arbitration happens only in IDLE
   // and TURN, so non-owner requests are ignored while a channel drives.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE, TURN: begin
            gnt_d   = '0;
            state_d = IDLE;
            if (any_req) begin
               state_d    = DRIVE;
               gnt_d[win] = 1'b1;
               owner_d    = win;
               ptr_d      = ptr_nxt;
            end
         end
         DRIVE: begin
            if (!req[owner_q] || timeout_hit) begin
               state_d = TURN;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         regs_q  <= '0;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // Bus outputs decode only registered state, so they switch together with gnt.
   assign gnt     = gnt_q;
   assign bus_vld = (state_q == DRIVE);
   assign bus     = bus_vld ? regs_q[owner_q] : {WIDTH{1'bz}};
   assign q       = regs_q;

endmodule

// File: tb/tb_tri_state_bus_arb.sv
// tb_tri_state_bus_arb
//
// Directed bench for tri_state_bus_arb (WIDTH=8, NUM_CH=4, MAX_HOLD=4).
// Inputs change 1 time unit after each posedge and outputs are sampled there.
// Compile with TRI_BUS_TIMEOUT_EN to exercise the hold-limit build.

module tb_tri_state_bus_arb;

   localparam int WIDTH    = 8;
   localparam int NUM_CH   = 4;
   localparam int MAX_HOLD = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  ld;
   logic [31:0] d;
   logic [3:0]  req;
   logic [3:0]  gnt;
   wire  [7:0]  bus;
   logic        bus_vld;
   logic [31:0] q;

   int nChecks;
   int nPass;

   tri_state_bus_arb #(
      .WIDTH   (WIDTH),
      .NUM_CH  (NUM_CH),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .d      (d),
      .req    (req),
      .gnt    (gnt),
      .bus    (bus),
      .bus_vld(bus_vld),
      .q      (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs across one posedge, then settle before sampling.
   task automatic applyStimulus(input logic r, input logic [3:0] l,
                                input logic [31:0] dd, input logic [3:0] rq);
      rst = r;
      ld  = l;
      d   = dd;
      req = rq;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         nPass++;
      end
   endtask

   // Bus state check: grant, valid, never more than one grant bit, and the
   // driven value whenever the bus is expected to be owned.
   task automatic checkBus(input string tag, input logic [3:0] expGnt,
                           input logic expVld, input logic [7:0] expData);
      checkOutput({tag, "_gnt"}, 64'(gnt), 64'(expGnt));
      checkOutput({tag, "_vld"}, 64'(bus_vld), 64'(expVld));
      checkOutput({tag, "_onehot"}, 64'($onehot0(gnt)), 64'(1));
      if (expVld) begin
         checkOutput({tag, "_bus"}, 64'(bus), 64'(expData));
      end
   endtask

   initial begin
      logic [7:0]  chVal [4];
      logic [3:0]  ownerBit;
      logic        expVld;
      nChecks = 0;
      nPass   = 0;
      rst = 1'b0;
      ld  = '0;
      d   = '0;
      req = '0;
      chVal[0] = 8'h11;
      chVal[1] = 8'h22;
      chVal[2] = 8'h33;
      chVal[3] = 8'h44;

      // Reset overrides simultaneous loads and requests.
      applyStimulus(1'b1, 4'hF, 32'hDEADBEEF, 4'hF);
      checkOutput("rst_q", 64'(q), 64'(0));
      checkBus("rst", 4'b0000, 1'b0, 8'h00);

      // Load ch2, request it, then reload it while it drives.
      applyStimulus(1'b0, 4'b0100, 32'h00A5_0000, 4'b0000);
      checkOutput("ld2_q", 64'(q), 64'h00A5_0000);
      checkBus("ld2_idle", 4'b0000, 1'b0, 8'h00);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0100);
      checkBus("gnt2", 4'b0100, 1'b1, 8'hA5);
      applyStimulus(1'b0, 4'b0100, 32'h003C_0000, 4'b0100);
      checkBus("reld2", 4'b0100, 1'b1, 8'h3C);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
      checkBus("rel2_turn", 4'b0000, 1'b0, 8'h00);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
      checkBus("rel2_idle", 4'b0000, 1'b0, 8'h00);

      // Reload all channels with distinct values.
      applyStimulus(1'b0, 4'hF, 32'h4433_2211, 4'b0000);
      checkOutput("ldall_q", 64'(q), 64'h4433_2211);

      // ch3 alone, then hand over to ch1 in the same cycle it drops.
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b1000);
      checkBus("gnt3", 4'b1000, 1'b1, 8'h44);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0010);
      checkBus("h31_turn", 4'b0000, 1'b0, 8'h00);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0010);
      checkBus("h31_gnt1", 4'b0010, 1'b1, 8'h22);

      // Pointer wrap: after ch3, ch0 beats ch2.
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b1000);
      checkBus("wrap_gnt3", 4'b1000, 1'b1, 8'h44);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0101);
      checkBus("wrap_turn", 4'b0000, 1'b0, 8'h00);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0101);
      checkBus("wrap_gnt0", 4'b0001, 1'b1, 8'h11);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);

      // Fresh reset so the pointer starts at 0, then reload the channels.
      applyStimulus(1'b1, 4'b0000, 32'h0, 4'b0000);
      checkOutput("rst2_q", 64'(q), 64'(0));
      applyStimulus(1'b0, 4'hF, 32'h4433_2211, 4'b0000);

      // All request; each owner drops for one cycle after two DRIVE cycles.
      for (int k = 0; k < 5; k++) begin
         ownerBit = 4'b0001 << (k % 4);
         applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF);
         checkBus($sformatf("rr%0d_a", k), ownerBit, 1'b1, chVal[k % 4]);
         applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF);
         checkBus($sformatf("rr%0d_b", k), ownerBit, 1'b1, chVal[k % 4]);
         applyStimulus(1'b0, 4'b0000, 32'h0, 4'hF & ~ownerBit);
         checkBus($sformatf("rr%0d_turn", k), 4'b0000, 1'b0, 8'h00);
      end
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);
      checkBus("rr_idle", 4'b0000, 1'b0, 8'h00);

      // Reset in mid-DRIVE on ch1 (pointer is 1 here).
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0010);
      checkBus("mid_gnt1", 4'b0010, 1'b1, 8'h22);
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0010);
      checkBus("mid_hold1", 4'b0010, 1'b1, 8'h22);
      applyStimulus(1'b1, 4'b0000, 32'h0, 4'b0010);
      checkBus("mid_rst", 4'b0000, 1'b0, 8'h00);
      checkOutput("mid_rst_q", 64'(q), 64'(0));
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0010);
      checkBus("mid_regnt1", 4'b0010, 1'b1, 8'h00);

      // Hold req[0] constant and watch bus_vld over 20 cycles.
      applyStimulus(1'b0, 4'b0001, 32'h0000_0077, 4'b0001);
      checkBus("hold_turn", 4'b0000, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0001);
`ifdef TRI_BUS_TIMEOUT_EN
         expVld = ((i % (MAX_HOLD + 1)) != MAX_HOLD);
`else
         expVld = 1'b1;
`endif
         checkBus($sformatf("hold%0d", i), expVld ? 4'b0001 : 4'b0000, expVld, 8'h77);
      end
      applyStimulus(1'b0, 4'b0000, 32'h0, 4'b0000);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/tri_state_bus_arb.md
# tri_state_bus_arb

Parametrised registered tri-state bus driver. NUM_CH channels each hold a WIDTH-bit register; a round-robin arbiter grants one channel at a time ownership of a shared tri-state output bus. A mandatory one-cycle high-Z turnaround separates consecutive owners so no two drivers ever overlap. This is the multi-channel, arbitrated generalisation of the single tri-state flip-flop, and sits between channel producers and a shared off-block bus.

## Interface
- WIDTH, 8, bits per channel register and bus width (>=1)
- NUM_CH, 4, number of channels (2..16)
- MAX_HOLD, 16, DRIVE-cycle limit per grant; used only with TRI_BUS_TIMEOUT_EN (>=1)

- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- ld  in  NUM_CH  per-channel load strobe; ld[i] captures d slice i
- d  in  NUM_CH*WIDTH  load data; channel i at bits [i*WIDTH +: WIDTH]
- req  in  NUM_CH  per-channel bus request, level-sensitive
- gnt  out  NUM_CH  registered one-hot grant; all-zero when no owner
- bus  out (tri)  WIDTH  owner's register when bus_vld=1, else all 'z
- bus_vld  out  1  high exactly when bus is actively driven
- q  out  NUM_CH*WIDTH  readback of all channel registers

## Operation
- Channel registers: on posedge, if ld[i], reg[i] <= d slice i. Loads are independent of arbitration; any subset may load in the same cycle.
- FSM states: IDLE, DRIVE, TURN.
  - IDLE: bus 'z, gnt 0. If any req bit is set, pick winner by round robin; next state DRIVE, gnt <= onehot(winner), owner <= winner.
  - DRIVE: bus = reg[owner], bus_vld 1. Stay while req[owner]=1. When req[owner]=0 on a posedge: next state TURN, gnt <= 0.
  - TURN: bus 'z, bus_vld 0, gnt 0 for exactly one cycle. Arbitrate exactly as in IDLE. Next state is DRIVE if any req is set, else IDLE.
- Round robin: pointer ptr holds (last owner + 1) mod NUM_CH, updated when a grant is issued. Search starts at ptr and wraps upward; the first set req wins.
- bus and bus_vld are combinational decodes of the registered state, owner and registers. The bus is glitch-free relative to gnt.
- Requests from non-owners during DRIVE are ignored until arbitration in TURN.

## Timing
- Reset (rst=1 at a posedge): all registers 0, ptr 0, state IDLE, gnt 0, bus_vld 0, bus all 'z. rst overrides ld and req in the same cycle. Reset in mid-DRIVE releases the bus at the next edge with no TURN cycle.
- Grant latency: req sampled high at posedge N in IDLE/TURN -> gnt and bus valid during cycle N+1.
- Release: req[owner] sampled low at posedge N -> bus 'z from cycle N+1. The earliest next owner drives from cycle N+2.
- An ld to the owner's channel at posedge N changes the bus value during cycle N+1, with no extra latency.
- Owner keeping req high through TURN does not skip TURN. It competes normally, and ptr has already advanced past it.

## Configuration
- TRI_BUS_TIMEOUT_EN defined: a hold counter clears on entry to DRIVE and increments each DRIVE cycle. When the count reaches MAX_HOLD, the FSM goes to TURN regardless of req[owner]. The sole requester may then be regranted.
- TRI_BUS_TIMEOUT_EN undefined: no counter is built; the owner holds indefinitely; MAX_HOLD is unused.

## Test plan
- Reset with ld=4'hF, d=32'hDEADBEEF, req=4'hF -> the next cycle shows q=0, gnt=0, bus_vld=0, bus=8'hzz.
- Load ch2=8'hA5, raise req[2] in IDLE -> gnt=4'b0100 and bus=8'hA5 on the next cycle. Then ld ch2=8'h3C while driving -> bus=8'h3C one cycle later.
- req=4'b1111 held, each owner drops req for 1 cycle after 2 DRIVE cycles -> grant order is ch0, ch1, ch2, ch3, ch0. There is exactly one 'z cycle (bus_vld=0, gnt=0) between owners, and there is never two gnt bits set.
- req[3] only, then drop it and raise req[1] in the same cycle -> one TURN cycle, then gnt=4'b0010. Also check ptr wrap: ch3 granted, followed by ch0 requesting, grants ch0.
- Apply rst mid-DRIVE on ch1 -> bus 'z and gnt 0 the next cycle. With req[1] still high after reset, ch1 is regranted after one IDLE cycle.
- With TRI_BUS_TIMEOUT_EN and MAX_HOLD=4, hold req[0] constant: bus_vld shows 4 cycles high, 1 cycle low, repeating. Without the macro, bus_vld stays high for 20+ cycles.
